// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: feeds wide operands nibble-by-nibble through an external 4-bit adder, LSB first.
// Define NIBBLE_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
`ifdef NIBBLE_SERIAL_OVF_EN
    output logic                 ovf,
`endif
    output logic                 out_cout
);
    localparam int W = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] opa, opb;
    logic [IW-1:0] idx;
    logic [IW+1:0] base;
    logic carry, last;
    // carry is preloaded with in_cin on acceptance, so it doubles as the LSB carry-in
    always_comb begin
        base = {idx, 2'b00};
        last = idx == LAST;
        in_ready = state == IDLE;
        out_valid = state == DONE;
        add_a = state == RUN ? opa[base +: 4] : 4'd0;
        add_b = state == RUN ? opb[base +: 4] : 4'd0;
        add_cin = state == RUN ? carry : 1'b0;
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            opa <= '0;
            opb <= '0;
            idx <= '0;
            carry <= 1'b0;
            out_sum <= '0;
            out_cout <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                opa <= in_a;
                opb <= in_b;
                carry <= in_cin;
                idx <= '0;
            end else if (state == RUN) begin
                out_sum[base +: 4] <= add_sum;
                carry <= add_cout;
                idx <= last ? idx : idx + 1'b1;
                if (last) begin
                    out_cout <= add_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
                    ovf <= (opa[W-1] == opb[W-1]) && (add_sum[3] != opa[W-1]);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// tb_nibble_serial_add_seq: randomized and directed checks against a plain-arithmetic reference model.
module tb_nibble_serial_add_seq;
    localparam int N = 4;
    localparam int W = 4 * N;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic in_valid = 0, in_cin = 0, out_ready = 0;
    logic in_ready, out_valid, out_cout, add_cin, add_cout;
    logic [W-1:0] in_a = 0, in_b = 0, out_sum;
    logic [3:0] add_a, add_b, add_sum;
    logic v1 = 0, cin1 = 0, or1 = 0;
    logic r1, ov1, co1, acin1, acout1;
    logic [3:0] a1 = 0, b1 = 0, s1, aa1, ab1, asum1;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic ovf, ovf1;
`endif
    int checks = 0, errors = 0;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign {acout1, asum1} = 5'(aa1) + 5'(ab1) + 5'(acin1);

    nibble_serial_add_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef NIBBLE_SERIAL_OVF_EN
        .ovf(ovf),
`endif
        .out_cout(out_cout));

    nibble_serial_add_seq #(.NIBBLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_b(b1), .in_cin(cin1),
        .add_a(aa1), .add_b(ab1), .add_cin(acin1), .add_sum(asum1), .add_cout(acout1),
        .out_valid(ov1), .out_ready(or1), .out_sum(s1),
`ifdef NIBBLE_SERIAL_OVF_EN
        .ovf(ovf1),
`endif
        .out_cout(co1));

    function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // carry entering nibble i is bit 4i of the sum of the operands' low 4i bits
    function automatic logic carry_into(logic [W-1:0] a, logic [W-1:0] b, logic c, int i);
        logic [W:0] m, s;
        m = ((W+1)'(1) << (4 * i)) - 1'b1;
        s = ((W+1)'(a) & m) + ((W+1)'(b) & m) + (W+1)'(c);
        return s[4*i];
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int hold);
        logic [W:0] exp;
        exp = ref_add(a, b, c);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = c; in_valid = 1; out_ready = 0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL op_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++) begin
            checks++;
            if (add_a !== 4'((a >> (4*i))) || add_b !== 4'((b >> (4*i))) || add_cin !== carry_into(a, b, c, i) || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL run_nibble%0d got a=%h b=%h cin=%b ov=%b want a=%h b=%h cin=%b ov=0", i, add_a, add_b, add_cin, out_valid,
                         4'((a >> (4*i))), 4'((b >> (4*i))), carry_into(a, b, c, i));
            end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_cout, out_sum} !== exp) begin
                errors++;
                $display("FAIL result a=%h b=%h c=%b got v=%b rdy=%b %b_%h want v=1 rdy=0 %b_%h", a, b, c, out_valid, in_ready, out_cout, out_sum, exp[W], exp[W-1:0]);
            end
            if (h < hold) @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_cout, out_sum} !== exp) begin
            errors++;
            $display("FAIL release got rdy=%b v=%b %b_%h want rdy=1 v=0 %b_%h", in_ready, out_valid, out_cout, out_sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset got rdy=%b v=%b sum=%h co=%b a=%h b=%h cin=%b want 1 0 0 0 0 0 0", in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin);
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got rdy=%b v=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0);
    endtask

    task automatic test_hold();
        @(negedge clk);
        in_a = 16'hA5A5; in_b = 16'h5A5A; in_cin = 0; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2 == 0); in_a = 16'h1111; in_b = 16'h1111;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'hFFFF || out_cout !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got v=%b rdy=%b sum=%h co=%b want 1 0 ffff 0", i, out_valid, in_ready, out_sum, out_cout);
            end
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'hFFFF) begin
            errors++;
            $display("FAIL hold_release got rdy=%b v=%b sum=%h want 1 0 ffff", in_ready, out_valid, out_sum);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || add_a !== 4'd0) begin errors++; $display("FAIL no_second_op got rdy=%b add_a=%h want 1 0", in_ready, add_a); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        in_a = 16'h00FF; in_b = 16'h0001; in_cin = 0; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL abort got rdy=%b v=%b sum=%h co=%b want 1 0 0 0", in_ready, out_valid, out_sum, out_cout);
        end
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid cycle%0d got v=%b want 0", i, out_valid); end
        end
        out_ready = 0;
        run_op(16'h0001, 16'h0001, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] exp;
        int last_acc = -1;
        out_ready = 1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            in_valid = 1'(cyc < 36);
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom_range(0, 1));
            if (out_valid) begin
                exp = q.size() > 0 ? q.pop_front() : 'x;
                checks++;
                if ({out_cout, out_sum} !== exp) begin errors++; $display("FAIL b2b_result got %b_%h want %b_%h", out_cout, out_sum, exp[W], exp[W-1:0]); end
            end
            if (in_ready && in_valid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== N + 2) begin errors++; $display("FAIL b2b_gap got %0d want %0d", cyc - last_acc, N + 2); end
                end
                last_acc = cyc;
                q.push_back(ref_add(in_a, in_b, in_cin));
            end
        end
        in_valid = 0; out_ready = 0;
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending want 0", q.size()); end
    endtask

`ifdef NIBBLE_SERIAL_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va[3] = '{16'h7FFF, 16'h8000, 16'h0001};
        logic [W-1:0] vb[3] = '{16'h0001, 16'h8000, 16'hFFFF};
        logic [W:0] s;
        logic exp;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, 0);
            s = ref_add(va[i], vb[i], 1'b0);
            exp = (va[i][W-1] == vb[i][W-1]) && (s[W-1] != va[i][W-1]);
            checks++;
            if (ovf !== exp) begin errors++; $display("FAIL ovf %h+%h got %b want %b", va[i], vb[i], ovf, exp); end
        end
    endtask
`endif

    task automatic test_n1();
        logic [4:0] q[$];
        logic [4:0] exp;
        int last_acc = -1;
        @(negedge clk);
        a1 = 4'hF; b1 = 4'h1; cin1 = 0; v1 = 1; or1 = 0;
        @(negedge clk);
        v1 = 0;
        checks++;
        if (ov1 !== 1'b0 || aa1 !== 4'hF || ab1 !== 4'h1) begin errors++; $display("FAIL n1_run got v=%b a=%h b=%h want 0 f 1", ov1, aa1, ab1); end
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b1 || s1 !== 4'h0 || co1 !== 1'b1) begin errors++; $display("FAIL n1_result got v=%b sum=%h co=%b want 1 0 1", ov1, s1, co1); end
        or1 = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            v1 = 1'(cyc < 15);
            a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom_range(0, 1));
            if (ov1) begin
                exp = q.size() > 0 ? q.pop_front() : 'x;
                checks++;
                if ({co1, s1} !== exp) begin errors++; $display("FAIL n1_b2b got %b_%h want %b_%h", co1, s1, exp[4], exp[3:0]); end
            end
            if (r1 && v1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 3) begin errors++; $display("FAIL n1_gap got %0d want 3", cyc - last_acc); end
                end
                last_acc = cyc;
                q.push_back(5'(a1) + 5'(b1) + 5'(cin1));
            end
        end
        v1 = 0; or1 = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_random();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_OVF_EN
        test_ovf();
`endif
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
